// File: rtl/indication_sched_pkg.sv
// Shared constants and state type for the indication pipe scheduler.
// Header field positions refer to word0 (the header beat) of each message.
package indication_sched_pkg;

    localparam int unsigned HDR_LEN_LSB = 0;
    localparam int unsigned HDR_LEN_MSB = 15;
    localparam int unsigned HDR_ID_LSB  = 16;
    localparam int unsigned HDR_ID_MSB  = 31;
    localparam int unsigned MAXB        = 4;

    typedef enum logic [0:0] {IDLE, SEND} sched_state_e;

endpackage

// File: rtl/indication_pipe_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request strictly after last_i,
// searching upward modulo NREQ.
module indication_pipe_sched_rr_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [NREQ-1:0]  grant_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDX_W'((32'(last_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/indication_pipe_sched.sv
// Shares one BEAT_W-wide indication pipe between NREQ requesters, serializing whole messages.
// Optional INDICATION_SCHED_STATS_EN adds message/clamp statistic counters.
module indication_pipe_sched
    import indication_sched_pkg::*;
#(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned MSG_W  = 128,
    parameter int unsigned BEAT_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_enq_ena,
    input  logic [NREQ*MSG_W-1:0] req_enq_v,
    output logic [NREQ-1:0]       req_enq_rdy,
    output logic                  pipe_enq_ena,
    output logic [BEAT_W-1:0]     pipe_enq_v,
    input  logic                  pipe_enq_rdy,
    output logic                  sched_err
`ifdef INDICATION_SCHED_STATS_EN
   ,output logic [31:0]           stat_msgs,
    output logic [15:0]           stat_errs
`endif
);

    localparam int unsigned MAXBEATS = MSG_W / BEAT_W;
    localparam int unsigned BL_W     = $clog2(MAXBEATS + 1);
    localparam int unsigned IDX_W    = $clog2(NREQ);

    logic [NREQ-1:0]   full_q, full_d;
    logic [MSG_W-1:0]  slot_q [NREQ];
    logic [MSG_W-1:0]  slot_d [NREQ];
    sched_state_e      state_q, state_d;
    logic [MSG_W-1:0]  shift_q, shift_d;
    logic [BL_W-1:0]   left_q, left_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   grant;
    logic [IDX_W-1:0]  grant_idx;
    logic [MSG_W-1:0]  sel_msg;
    logic [15:0]       len;
    logic              len_bad;
    logic [BL_W-1:0]   len_beats;
    logic              last_accept;

    indication_pipe_sched_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i   (full_q),
        .last_i  (last_q),
        .grant_o (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
        sel_msg = slot_q[grant_idx];
        len     = sel_msg[HDR_LEN_MSB:HDR_LEN_LSB];
        len_bad = (len == 16'd0) || (len > 16'(MAXBEATS));
        // Header beat is sent unmodified; only the beat count is clamped.
        if (len == 16'd0)                len_beats = BL_W'(1);
        else if (len > 16'(MAXBEATS))    len_beats = BL_W'(MAXBEATS);
        else                             len_beats = BL_W'(len);
    end

    assign last_accept = (state_q == SEND) && pipe_enq_rdy && (left_q == BL_W'(1));

    always_comb begin
        full_d  = full_q;
        slot_d  = slot_q;
        state_d = state_q;
        shift_d = shift_q;
        left_d  = left_q;
        last_d  = last_q;
        err_d   = 1'b0;
        // Enqueue into a full slot is ignored.
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_enq_ena[i] && !full_q[i]) begin
                full_d[i] = 1'b1;
                slot_d[i] = req_enq_v[i*MSG_W +: MSG_W];
            end
        end
        unique case (state_q)
            IDLE: begin
                if (|full_q) begin
                    full_d[grant_idx] = 1'b0;
                    shift_d           = sel_msg;
                    left_d            = len_beats;
                    last_d            = grant_idx;
                    err_d             = len_bad;
                    state_d           = SEND;
                end
            end
            SEND: begin
                if (pipe_enq_rdy) begin
                    shift_d = shift_q >> BEAT_W;
                    left_d  = left_q - BL_W'(1);
                    if (left_q == BL_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            full_q  <= '0;
            for (int unsigned i = 0; i < NREQ; i++) slot_q[i] <= '0;
            state_q <= IDLE;
            shift_q <= '0;
            left_q  <= '0;
            last_q  <= IDX_W'(NREQ - 1);
            err_q   <= 1'b0;
        end else begin
            full_q  <= full_d;
            slot_q  <= slot_d;
            state_q <= state_d;
            shift_q <= shift_d;
            left_q  <= left_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign req_enq_rdy  = ~full_q;
    assign pipe_enq_ena = (state_q == SEND);
    assign pipe_enq_v   = shift_q[BEAT_W-1:0];
    assign sched_err    = err_q;

`ifdef INDICATION_SCHED_STATS_EN
    logic [31:0] msgs_q, msgs_d;
    logic [15:0] errs_q, errs_d;

    always_comb begin
        msgs_d = msgs_q + (last_accept ? 32'd1 : 32'd0);
        errs_d = errs_q + (err_d ? 16'd1 : 16'd0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            msgs_q <= '0;
            errs_q <= '0;
        end else begin
            msgs_q <= msgs_d;
            errs_q <= errs_d;
        end
    end

    assign stat_msgs = msgs_q;
    assign stat_errs = errs_q;
`else
    logic unused_last_accept;
    assign unused_last_accept = last_accept;
`endif

endmodule

// File: tb/tb_indication_pipe_sched.sv
// Directed bench for indication_pipe_sched: beat-stream model plus literal timing checks.
// Build with INDICATION_SCHED_STATS_EN to also check the statistic counters.
module tb_indication_pipe_sched;

    logic         CLK = 1'b0;
    logic         RST;
    logic [2:0]   req_ena;
    logic [383:0] req_v;
    logic [2:0]   req_rdy;
    logic         pipe_ena;
    logic [31:0]  pipe_v;
    logic         pipe_rdy;
    logic         err_o;
`ifdef INDICATION_SCHED_STATS_EN
    logic [31:0]  st_msgs;
    logic [15:0]  st_errs;
`endif

    indication_pipe_sched #(
        .NREQ   (3),
        .MSG_W  (128),
        .BEAT_W (32)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_enq_ena  (req_ena),
        .req_enq_v    (req_v),
        .req_enq_rdy  (req_rdy),
        .pipe_enq_ena (pipe_ena),
        .pipe_enq_v   (pipe_v),
        .pipe_enq_rdy (pipe_rdy),
        .sched_err    (err_o)
`ifdef INDICATION_SCHED_STATS_EN
       ,.stat_msgs    (st_msgs),
        .stat_errs    (st_errs)
`endif
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];
    int exp_errs = 0;
    int exp_msgs = 0;
    int seen_errs = 0;
    int accepts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk(input logic [15:0] id, input logic [15:0] len,
                                        input logic [31:0] w1, input logic [31:0] w2,
                                        input logic [31:0] w3);
        return {w3, w2, w1, id, len};
    endfunction

    // Model: a message becomes min(max(len,1),4) beats; a clamp counts as one error.
    task automatic push_msg(input logic [127:0] m);
        int n;
        int len;
        len = int'(m[15:0]);
        n = (len == 0) ? 1 : ((len > 4) ? 4 : len);
        if (len == 0 || len > 4) exp_errs++;
        exp_msgs++;
        for (int k = 0; k < n; k++) exp_q.push_back(m[k*32 +: 32]);
    endtask

    // Compare process: every accepted beat against the model stream, held beats stable.
    initial begin
        logic        prev_ena;
        logic        prev_rdy;
        logic [31:0] prev_v;
        prev_ena = 1'b0;
        prev_rdy = 1'b0;
        prev_v   = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_ena = 1'b0;
            end else begin
                if (pipe_ena && prev_ena && !prev_rdy) check("held_beat", pipe_v, prev_v);
                if (pipe_ena && pipe_rdy) begin
                    accepts++;
                    if (exp_q.size() == 0) check("unexpected_beat", pipe_v, 32'hxxxx_xxxx);
                    else check("beat", pipe_v, exp_q.pop_front());
                end
                if (err_o) seen_errs++;
                prev_ena = pipe_ena;
                prev_rdy = pipe_rdy;
                prev_v   = pipe_v;
            end
        end
    end

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RST     = 1'b1;
        req_ena = '0;
        exp_q.delete();
        exp_errs  = 0;
        exp_msgs  = 0;
        seen_errs = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic enq(input logic [2:0] mask, input logic [127:0] m0,
                       input logic [127:0] m1, input logic [127:0] m2);
        @(posedge CLK);
        #1;
        req_ena = mask;
        req_v   = {m2, m1, m0};
        @(posedge CLK);
        #1 req_ena = '0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 300;
        while ((exp_q.size() != 0 || pipe_ena) && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        check({name, "_drain_timeout"}, (budget == 0) ? 32'd1 : 32'd0, 32'd0);
        repeat (2) @(negedge CLK);
        check({name, "_errs"}, 32'(seen_errs), 32'(exp_errs));
    endtask

    task automatic wait_ena(input string name);
        int budget;
        budget = 50;
        @(negedge CLK);
        while (!pipe_ena && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        check({name, "_ena_timeout"}, (budget == 0) ? 32'd1 : 32'd0, 32'd0);
    endtask

    logic [127:0] ma, mb, mc;
    logic [8:0]   pat;
    int           a0;
    int           cnt;

    initial begin
        RST      = 1'b1;
        req_ena  = '0;
        req_v    = '0;
        pipe_rdy = 1'b1;
        #2;
        check("rst_ena", 32'(pipe_ena), 32'd0);
        check("rst_v", pipe_v, 32'd0);
        check("rst_rdy", 32'(req_rdy), 32'd7);
        check("rst_err", 32'(err_o), 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // 1: single len=2 message, literal timing.
        ma = mk(16'd0, 16'd2, 32'hA, 32'h0, 32'h0);
        push_msg(ma);
        enq(3'b001, ma, '0, '0);
        @(negedge CLK);
        check("t1_grant_cycle_ena", 32'(pipe_ena), 32'd0);
        check("t1_slot_full", 32'(req_rdy[0]), 32'd0);
        @(negedge CLK);
        check("t1_beat0_ena", 32'(pipe_ena), 32'd1);
        check("t1_beat0", pipe_v, 32'h0000_0002);
        check("t1_slot_freed", 32'(req_rdy[0]), 32'd1);
        @(negedge CLK);
        check("t1_beat1", pipe_v, 32'h0000_000A);
        @(negedge CLK);
        check("t1_idle_after", 32'(pipe_ena), 32'd0);
        drain("t1");

        // 2: three simultaneous requesters, then a refill; order 0,1,2 both times.
        do_reset();
        ma = mk(16'h10, 16'd4, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003);
        mb = mk(16'h11, 16'd3, 32'h2222_0001, 32'h2222_0002, 32'h2222_0003);
        mc = mk(16'h12, 16'd2, 32'h3333_0001, 32'h3333_0002, 32'h3333_0003);
        push_msg(ma); push_msg(mb); push_msg(mc);
        enq(3'b111, ma, mb, mc);
        drain("t2a");
        ma[31:16] = 16'h20; mb[31:16] = 16'h21; mc[31:16] = 16'h22;
        push_msg(ma); push_msg(mb); push_msg(mc);
        enq(3'b111, ma, mb, mc);
        drain("t2b");

        // 3: stall three cycles on beat 1.
        ma = mk(16'h30, 16'd4, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
        push_msg(ma);
        a0 = accepts;
        enq(3'b001, ma, '0, '0);
        wait_ena("t3");
        @(posedge CLK);
        #1 pipe_rdy = 1'b0;
        repeat (3) @(posedge CLK);
        #1 pipe_rdy = 1'b1;
        drain("t3");
        check("t3_accepts", 32'(accepts - a0), 32'd4);

        // 4: length clamps.
        do_reset();
        ma = mk(16'h40, 16'd0, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);
        push_msg(ma);
        enq(3'b010, '0, ma, '0);
        drain("t4a");
        mb = mk(16'h41, 16'd7, 32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003);
        push_msg(mb);
        enq(3'b010, '0, mb, '0);
        drain("t4b");
        check("t4_err_total", 32'(seen_errs), 32'd2);
`ifdef INDICATION_SCHED_STATS_EN
        check("t4_stat_errs", 32'(st_errs), 32'd2);
        check("t4_stat_msgs", st_msgs, 32'(exp_msgs));
`endif

        // 5: reset during beat 1 of 4.
        ma = mk(16'h50, 16'd4, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003);
        push_msg(ma);
        enq(3'b100, '0, '0, ma);
        wait_ena("t5");
        @(posedge CLK);
        #1 RST = 1'b1;
        exp_q.delete();
        #1;
        check("t5_async_ena", 32'(pipe_ena), 32'd0);
        check("t5_async_rdy", 32'(req_rdy), 32'd7);
        check("t5_async_v", pipe_v, 32'd0);
        exp_errs  = 0;
        exp_msgs  = 0;
        seen_errs = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge CLK);
            if (pipe_ena) cnt++;
        end
        check("t5_no_stale_beats", 32'(cnt), 32'd0);
        check("t5_rdy_after", 32'(req_rdy), 32'd7);
`ifdef INDICATION_SCHED_STATS_EN
        check("t5_stat_msgs", st_msgs, 32'd0);
`endif

        // 6: req1 reloads while its previous message is sending.
        ma = mk(16'h60, 16'd3, 32'h6666_0001, 32'h6666_0002, 32'h0);
        mb = mk(16'h61, 16'd3, 32'h7777_0001, 32'h7777_0002, 32'h0);
        push_msg(ma); push_msg(mb);
        @(posedge CLK);
        #1;
        req_ena = 3'b010;
        req_v[128 +: 128] = ma;
        @(posedge CLK);
        #1 req_ena = '0;
        @(negedge CLK);
        pat[0] = pipe_ena;
        @(posedge CLK);
        #1;
        check("t6_reload_rdy", 32'(req_rdy[1]), 32'd1);
        req_ena = 3'b010;
        req_v[128 +: 128] = mb;
        @(negedge CLK);
        pat[1] = pipe_ena;
        @(posedge CLK);
        #1 req_ena = '0;
        for (int k = 2; k < 9; k++) begin
            @(negedge CLK);
            pat[k] = pipe_ena;
        end
        check("t6_ena_pattern", 32'(pat), 32'(9'b011101110));
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
